prog_timer: RTL and testbench
=============================

Name: prog_timer

Overview:
Parametrised successor to the single-shot traffic-light phase timer. It counts a programmable number of ticks, where one tick is PRESCALE clock cycles. It supports one-shot and auto-reload modes, pause, abort and restart, and exposes the remaining count. It sits between the traffic-light FSM (which issues start_timer/value per phase) and the phase-duration logic.

Parameters:
WIDTH, 8, bit width of value, reload register and remaining count
PRESCALE, 1, clock cycles per tick (>=1); 1 = decrement every cycle
WARN_THRESH, 2, remaining-count threshold for warn (used only with TIMER_WARN_EN)

Ports:
clk1  in  1  single system clock, rising-edge
reset  in  1  synchronous, active-high reset
start_timer  in  1  load value and start counting (sampled each rising edge)
value  in  WIDTH  tick count to load on start_timer
auto_reload  in  1  sampled with start_timer; 1 = reload value on expiry and keep running
pause  in  1  hold count and prescaler while high
abort  in  1  stop immediately, no expiry
expired  out  1  one-cycle pulse on expiry
busy  out  1  high in RUN or PAUSE
remaining  out  WIDTH  current count
warn  out  1  only with TIMER_WARN_EN

Behaviour:
- Reset (synchronous, active-high, clk1) → state IDLE, count=0, reload=0, mode=0, prescaler=0, expired=0, busy=0, remaining=0, warn=0.
- Per-edge priority: reset > abort > start_timer > pause > normal count.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, prescaler advances.
  - PAUSE: busy=1, prescaler and count frozen.
- start_timer at edge E0 with value=N>0:
  - count←N, reload←N, mode←auto_reload, prescaler←0, state→RUN.
  - Applies from any state, so it restarts a running or paused timer.
- Tick: in RUN, when prescaler==PRESCALE-1 → prescaler←0 and tick; otherwise prescaler+1.
- On tick with count>1: count−1.
- On tick with count==1:
  - expired=1 for exactly one cycle.
  - mode=0: count←0, state→IDLE.
  - mode=1: count←reload, stay RUN, no gap cycle.
- Latency: expired rises at edge E0+N·PRESCALE and falls at the next edge.
  - Example: PRESCALE=1, N=7 → expired high during cycle after edge E0+7.
- value=0 on start_timer:
  - expired pulses at E0+1 and state stays IDLE, regardless of auto_reload.
  - busy never rises.
- pause=1 in RUN → PAUSE at next edge. pause=0 in PAUSE → RUN.
  - Each cycle in PAUSE extends expiry by one cycle.
  - pause in IDLE is ignored.
- abort → IDLE, count=0, prescaler=0, expired=0 next cycle.
  - An expiry due on the same edge is suppressed.
- start_timer coincident with a tick-expiry edge: the restart wins and no expired pulse is produced.
- remaining: registered count, updates on the same edge as count. Values are unsigned; no underflow is possible.
- Reset asserted mid-count returns to the reset state on that edge, with no expired pulse.

Optional Feature:
Macro TIMER_WARN_EN.
- Defined: warn is registered and equals busy && (count <= WARN_THRESH) && (count != 0); it is evaluated on the post-edge count. Intended for the amber pre-warning.
- Not defined: the warn port is still present and tied to 0; no comparator logic is generated.

Decomposition:
- Shared package timer_pkg holds:
  - state enum (IDLE, RUN, PAUSE) as 2-bit localparams
  - default WIDTH/PRESCALE constants
  - phase-duration constants for the traffic-light FSM
- Natural sub-module: tick_gen, the PRESCALE divider with clear/enable inputs and a tick output. Degenerates to tick=enable when PRESCALE=1.

Test Plan:
1. PRESCALE=1, WIDTH=4, start_timer with value=7 at E0 → busy=1 from E0+1; remaining 7,6,…,1; expired one-cycle at E0+7; busy=0 after.
2. PRESCALE=3, value=4, auto_reload=1 → expired pulses at E0+12, E0+24, E0+36; busy stays 1; remaining reloads to 4 with no gap.
3. value=5, PRESCALE=1, pause high for 3 cycles starting E0+2 → expired at E0+8; remaining holds 3 during pause.
4. value=6, abort at E0+3 → busy=0, remaining=0 at E0+4; no expired pulse ever.
5. Restart edge cases:
   - value=3 running; start_timer with value=2 at E0+3, the expiry edge → no pulse at E0+3; expired at E0+5.
   - value=0 → single expired pulse at E0+1; busy stays 0.
6. TIMER_WARN_EN, WARN_THRESH=2, value=5 → warn high while remaining is 2 and 1; low at 0, after expiry, and after abort.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the programmable phase timer and the traffic-light
// controller that drives it.
package timer_pkg;

  // Timer FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } timer_state_e;

  // Default build parameters.
  localparam int TIMER_WIDTH_DEFAULT    = 8;
  localparam int TIMER_PRESCALE_DEFAULT = 1;
  localparam int TIMER_WARN_DEFAULT     = 2;

  // Phase durations (in ticks) used by the traffic-light FSM.
  localparam int PHASE_GREEN_TICKS = 30;
  localparam int PHASE_AMBER_TICKS = 4;
  localparam int PHASE_RED_TICKS   = 25;
  localparam int PHASE_ALLRED_TICKS = 2;

endpackage

// File: rtl/tick_gen.sv
// Prescale divider: emits one tick every PRESCALE enabled cycles.
// clear restarts the divider phase; with PRESCALE=1 tick simply follows enable
// because the phase counter can never leave zero.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk1,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("tick_gen: PRESCALE must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  // Next phase: clear wins, otherwise advance while enabled and wrap on tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Phase register.
  always_ff @(posedge clk1) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable tick timer with one-shot / auto-reload modes, pause, abort and
// restart. Optional amber pre-warning output is built only when the macro
// TIMER_WARN_EN is defined; otherwise warn is tied low.
//
// Handshake: start_timer, pause and abort are level inputs sampled on every
// rising clk1 edge (priority reset > abort > start_timer > pause > count);
// expired is a single-cycle pulse with no acknowledge.
module prog_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = TIMER_WIDTH_DEFAULT,
  parameter int PRESCALE    = TIMER_PRESCALE_DEFAULT,
  parameter int WARN_THRESH = TIMER_WARN_DEFAULT
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [WIDTH-1:0] value,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic             expired,
  output logic             busy,
  output logic [WIDTH-1:0] remaining,
  output logic             warn,
  output logic [1:0]       state_dbg
);

  if (WARN_THRESH < 0) begin : g_bad_thresh
    $error("prog_timer: WARN_THRESH must be non-negative");
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  // A zero-length start reports expiry one edge later without ever running.
  logic             zero_pend_q, zero_pend_d;
  logic             expired_q, expired_d;
  logic             busy_q;
  logic             tick;

  // The divider runs only while busy and not being held; any restart or
  // abort realigns it so the first tick lands PRESCALE cycles later.
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk1   (clk1),
    .reset  (reset),
    .clear  (abort || start_timer),
    .enable ((state_q != ST_IDLE) && !pause),
    .tick   (tick)
  );

  // Next-state logic in edge priority order: abort, start, pause, count.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    reload_d    = reload_q;
    mode_d      = mode_q;
    zero_pend_d = 1'b0;
    expired_d   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start_timer) begin
      if (value == '0) begin
        state_d     = ST_IDLE;
        count_d     = '0;
        reload_d    = '0;
        mode_d      = 1'b0;
        zero_pend_d = 1'b1;
      end else begin
        state_d  = ST_RUN;
        count_d  = value;
        reload_d = value;
        mode_d   = auto_reload;
      end
    end else begin
      expired_d = zero_pend_q;
      if (state_q != ST_IDLE) begin
        if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          // Leaving PAUSE counts as a running cycle, so each paused cycle
          // delays expiry by exactly one cycle.
          state_d = ST_RUN;
          if (tick) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              expired_d = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
    end
  end

  // Timer FSM and registered outputs.
  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      reload_q    <= '0;
      mode_q      <= 1'b0;
      zero_pend_q <= 1'b0;
      expired_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      reload_q    <= reload_d;
      mode_q      <= mode_d;
      zero_pend_q <= zero_pend_d;
      expired_q   <= expired_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

`ifdef TIMER_WARN_EN
  logic warn_q;

  // Pre-warning tracks the post-edge count while the timer is active.
  always_ff @(posedge clk1) begin
    if (reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= (state_d != ST_IDLE) && (count_d <= WIDTH'(WARN_THRESH)) &&
                (count_d != '0);
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign expired   = expired_q;
  assign busy      = busy_q;
  assign remaining = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_prog_timer.sv
// Bench for prog_timer: two instances (PRESCALE=1/WIDTH=4 and
// PRESCALE=3/WIDTH=8) share one stimulus stream and are compared each cycle
// against a tick-counting reference model.
module tb_prog_timer;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [3:0] val4 = '0;
  logic [7:0] val8;
  logic       auto_reload = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;

  assign val8 = {4'd0, val4};

  logic       exp_a, busy_a, warn_a;
  logic [3:0] rem_a;
  logic [1:0] st_a;
  logic       exp_b, busy_b, warn_b;
  logic [7:0] rem_b;
  logic [1:0] st_b;

  prog_timer #(.WIDTH(4), .PRESCALE(1), .WARN_THRESH(2)) u_dut_a (
    .clk1(clk1), .reset(reset), .start_timer(start_timer), .value(val4),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .expired(exp_a), .busy(busy_a), .remaining(rem_a), .warn(warn_a),
    .state_dbg(st_a)
  );

  prog_timer #(.WIDTH(8), .PRESCALE(3), .WARN_THRESH(2)) u_dut_b (
    .clk1(clk1), .reset(reset), .start_timer(start_timer), .value(val8),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .expired(exp_b), .busy(busy_b), .remaining(rem_b), .warn(warn_b),
    .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];   // directed expected remaining values (instance a)
  logic [7:0] expx_q[$];  // directed expected expired values (instance a)

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: active flag, ticks left, reload length, repeat flag,
  // cycles spent in the current tick, and a deferred zero-length expiry.
  int  ps[2] = '{1, 3};
  bit  m_busy[2];
  int  m_cnt[2];
  int  m_rel[2];
  bit  m_rep[2];
  int  m_ph[2];
  bit  m_zero[2];
  bit  m_exp[2];
  bit  m_warn[2];

  task automatic model_step(input int k, input bit rs, input bit st, input int v,
                            input bit ar, input bit pa, input bit ab);
    m_exp[k] = 1'b0;
    if (rs) begin
      m_busy[k] = 0; m_cnt[k] = 0; m_rel[k] = 0; m_rep[k] = 0; m_ph[k] = 0; m_zero[k] = 0;
    end else if (ab) begin
      m_busy[k] = 0; m_cnt[k] = 0; m_ph[k] = 0; m_zero[k] = 0;
    end else if (st) begin
      m_ph[k] = 0;
      if (v == 0) begin
        m_busy[k] = 0; m_cnt[k] = 0; m_rel[k] = 0; m_rep[k] = 0; m_zero[k] = 1;
      end else begin
        m_busy[k] = 1; m_cnt[k] = v; m_rel[k] = v; m_rep[k] = ar; m_zero[k] = 0;
      end
    end else begin
      if (m_zero[k]) begin
        m_exp[k] = 1'b1;
        m_zero[k] = 0;
      end
      if (m_busy[k] && !pa) begin
        m_ph[k] = m_ph[k] + 1;
        if (m_ph[k] == ps[k]) begin
          m_ph[k] = 0;
          m_cnt[k] = m_cnt[k] - 1;
          if (m_cnt[k] == 0) begin
            m_exp[k] = 1'b1;
            if (m_rep[k]) m_cnt[k] = m_rel[k];
            else m_busy[k] = 0;
          end
        end
      end
    end
`ifdef TIMER_WARN_EN
    m_warn[k] = m_busy[k] && (m_cnt[k] <= 2) && (m_cnt[k] != 0);
`else
    m_warn[k] = 1'b0;
`endif
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of inputs, advance the model and compare both instances.
  task automatic drive(input bit rs, input bit st, input int v, input bit ar,
                       input bit pa, input bit ab);
    @(negedge clk1);
    reset = rs; start_timer = st; val4 = v[3:0]; auto_reload = ar; pause = pa; abort = ab;
    @(posedge clk1);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, rs, st, v, ar, pa, ab);
    check("a_expired", {31'd0, exp_a}, {31'd0, m_exp[0]});
    check("a_busy", {31'd0, busy_a}, {31'd0, m_busy[0]});
    check("a_remaining", {28'd0, rem_a}, m_cnt[0]);
    check("a_warn", {31'd0, warn_a}, {31'd0, m_warn[0]});
    check("b_expired", {31'd0, exp_b}, {31'd0, m_exp[1]});
    check("b_busy", {31'd0, busy_b}, {31'd0, m_busy[1]});
    check("b_remaining", {24'd0, rem_b}, m_cnt[1]);
    check("b_warn", {31'd0, warn_b}, {31'd0, m_warn[1]});
    if (exp_q.size() > 0) check("dir_remaining", {28'd0, rem_a}, {24'd0, exp_q.pop_front()});
    if (expx_q.size() > 0) check("dir_expired", {31'd0, exp_a}, {24'd0, expx_q.pop_front()});
  endtask

  task automatic idle(input int n, input bit pa);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, pa, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_remaining", {28'd0, rem_a}, 32'd0);
    check("rst_expired", {31'd0, exp_b}, 32'd0);
    idle(2, 1);  // pause while idle is ignored

    // One-shot, value 7, PRESCALE=1: remaining 7..1 then 0 with a pulse.
    for (int i = 7; i >= 1; i--) begin
      exp_q.push_back(8'(i));
      expx_q.push_back(8'd0);
    end
    exp_q.push_back(8'd0);
    expx_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    expx_q.push_back(8'd0);
    drive(0, 1, 7, 0, 0, 0);
    idle(30, 0);

    // Auto-reload, value 4: periodic pulses on both prescales.
    drive(0, 1, 4, 1, 0, 0);
    idle(40, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(2, 0);

    // Pause for three cycles mid-count.
    drive(0, 1, 5, 0, 0, 0);
    idle(2, 0);
    idle(3, 1);
    idle(20, 0);

    // Abort mid-count.
    drive(0, 1, 6, 0, 0, 0);
    idle(2, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(10, 0);

    // Restart exactly on the expiry edge, then a zero-length start.
    drive(0, 1, 3, 0, 0, 0);
    idle(2, 0);
    drive(0, 1, 2, 0, 0, 0);
    idle(8, 0);
    drive(0, 1, 0, 1, 0, 0);
    idle(4, 0);

    // Reset mid-count.
    drive(0, 1, 9, 0, 0, 0);
    idle(2, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle(3, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit rs, st, ar, pa, ab;
      int v;
      rs = ($urandom_range(0, 199) == 0);
      ab = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 11) == 0);
      ar = $urandom_range(0, 1);
      pa = ($urandom_range(0, 4) == 0);
      v  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15);
      drive(rs, st, v, ar, pa, ab);
    end

    if (exp_q.size() != 0 || expx_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL dir_queue: %0d entries left, expected 0", exp_q.size() + expx_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
